// File: rtl/npu_layer_seq_pkg.sv
// npu_layer_seq shared definitions: FSM encodings, stretcher map, defaults.
// Imported by the sequencer, its interface and the pulse stretcher.
package npu_layer_seq_pkg;

    localparam int DEF_LYR_W   = 8;
    localparam int DEF_TILE_W  = 10;
    localparam int DEF_PULSE_W = 4;

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_FETCH = 4'd1;
    localparam logic [3:0] ST_PDONE = 4'd2;
    localparam logic [3:0] ST_RST   = 4'd3;
    localparam logic [3:0] ST_WRST  = 4'd4;
    localparam logic [3:0] ST_CAL   = 4'd5;
    localparam logic [3:0] ST_WCAL  = 4'd6;
    localparam logic [3:0] ST_WTX   = 4'd7;
    localparam logic [3:0] ST_TX    = 4'd8;
    localparam logic [3:0] ST_TXD   = 4'd9;
    localparam logic [3:0] ST_NEXT  = 4'd10;
    localparam logic [3:0] ST_FIN   = 4'd11;

    localparam int NUM_P  = 5;
    localparam int P_PARA = 0;
    localparam int P_IFM  = 1;
    localparam int P_WT   = 2;
    localparam int P_CAL  = 3;
    localparam int P_TXD  = 4;

    // One-hot select of the stretcher owned by a pulse-issuing state
    function automatic logic [NUM_P-1:0] pulse_sel(input logic [3:0] st);
        logic [NUM_P-1:0] s;
        s = '0;
        case (st)
            ST_PDONE: s[P_PARA] = 1'b1;
            ST_RST:   s[P_IFM]  = 1'b1;
            ST_WRST:  s[P_WT]   = 1'b1;
            ST_CAL:   s[P_CAL]  = 1'b1;
            ST_TXD:   s[P_TXD]  = 1'b1;
            default:  s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/npu_layer_seq_if.sv
// Parameter-fetch and OFM-transfer handshakes of the layer sequencer.
// master = sequencer, slave = fetch/DMA side.
interface npu_layer_seq_if
    import npu_layer_seq_pkg::*;
#(
    parameter int TILE_W = DEF_TILE_W
);
    logic              para_req;
    logic              para_ack;
    logic [TILE_W-1:0] para_tile_num;
    logic              tx_req;
    logic              tx_done;

    modport master (
        output para_req, tx_req,
        input  para_ack, para_tile_num, tx_done
    );

    modport slave (
        input  para_req, tx_req,
        output para_ack, para_tile_num, tx_done
    );
endinterface

// File: rtl/npu_layer_seq_pulse_stretch.sv
// Holds a one-cycle trigger high for PULSE_W cycles starting the next cycle
// so the clk_cal edge detector cannot miss it.
module npu_layer_seq_pulse_stretch
    import npu_layer_seq_pkg::*;
#(
    parameter int PULSE_W = DEF_PULSE_W
) (
    input  logic clk_trans,
    input  logic rst_n,
    input  logic trig,
    output logic pulse,
    output logic idle
);
    localparam int CW = $clog2(PULSE_W + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_trans or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (trig) begin
            cnt <= CW'(PULSE_W);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign pulse = (cnt != '0);
    assign idle  = (cnt == '0);
endmodule

// File: rtl/npu_layer_seq.sv
// clk_trans layer/tile sequencer: fetches layer params, drives stretched
// PE control pulses per tile and hands finished OFM tiles to the DMA.
module npu_layer_seq
    import npu_layer_seq_pkg::*;
#(
    parameter int LYR_W   = DEF_LYR_W,
    parameter int TILE_W  = DEF_TILE_W,
    parameter int PULSE_W = DEF_PULSE_W
) (
    input  logic              clk_trans,
    input  logic              rst_n,
    input  logic              net_start,
    input  logic [LYR_W-1:0]  lyr_num,
    output logic              busy,
    output logic              net_done,
    npu_layer_seq_if.master   bus,
    output logic              pe_cal_start,
    output logic              pe_ifm_rst,
    output logic              pe_wt_rst,
    output logic              pe_first_bn,
    output logic              pe_last_bn,
    output logic              pe_tx_ofm_done,
    output logic              pe_ft_lyr_para_done,
    input  logic              pe_cal_done_sync,
    input  logic              pe_tx_ofm_start_sync,
    output logic [LYR_W-1:0]  lyr_idx,
    output logic [TILE_W-1:0] tile_idx
);
    logic [3:0]        state;
    logic [3:0]        state_nx;
    logic [LYR_W-1:0]  lyr_num_q;
    logic [TILE_W-1:0] tile_num_q;
    logic              issued;
    logic [NUM_P-1:0]  sel;
    logic [NUM_P-1:0]  trig;
    logic [NUM_P-1:0]  st_out;
    logic [NUM_P-1:0]  st_idle;
    logic              pulse_st;
    logic              pulse_done;
    logic              tile_more;
    logic              lyr_more;
    logic              cal_done_f;
    logic              txs_f;

    // Each pulse state fires its stretcher once, then waits for it to drain
    assign sel        = pulse_sel(state);
    assign pulse_st   = |sel;
    assign trig       = issued ? '0 : sel;
    assign pulse_done = issued && |(sel & st_idle);

    assign tile_more = tile_idx < (tile_num_q - TILE_W'(1));
    assign lyr_more  = lyr_idx < (lyr_num_q - LYR_W'(1));

    for (genvar i = 0; i < NUM_P; i++) begin : g_ps
        npu_layer_seq_pulse_stretch #(
            .PULSE_W (PULSE_W)
        ) u_ps (
            .clk_trans (clk_trans),
            .rst_n     (rst_n),
            .trig      (trig[i]),
            .pulse     (st_out[i]),
            .idle      (st_idle[i])
        );
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:
                if (net_start)
                    state_nx = (lyr_num == '0) ? ST_FIN : ST_FETCH;
            ST_FETCH: if (bus.para_ack) state_nx = ST_PDONE;
            ST_PDONE: if (pulse_done) state_nx = ST_RST;
            ST_RST:
                if (pulse_done)
                    state_nx = (tile_idx == '0) ? ST_WRST : ST_CAL;
            ST_WRST:  if (pulse_done) state_nx = ST_CAL;
            ST_CAL:   if (pulse_done) state_nx = ST_WCAL;
            ST_WCAL:  if (cal_done_f) state_nx = ST_WTX;
            ST_WTX:   if (txs_f) state_nx = ST_TX;
            ST_TX:    if (bus.tx_done) state_nx = ST_TXD;
            ST_TXD:   if (pulse_done) state_nx = ST_NEXT;
            ST_NEXT: begin
                if (tile_more)     state_nx = ST_RST;
                else if (lyr_more) state_nx = ST_FETCH;
                else               state_nx = ST_FIN;
            end
            ST_FIN:   state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_trans or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            issued     <= 1'b0;
            busy       <= 1'b0;
            net_done   <= 1'b0;
            lyr_num_q  <= '0;
            tile_num_q <= '0;
            lyr_idx    <= '0;
            tile_idx   <= '0;
        end else begin
            state    <= state_nx;
            issued   <= pulse_st && !pulse_done;
            net_done <= (state == ST_FIN);
            case (state)
                ST_IDLE:
                    if (net_start) begin
                        lyr_num_q <= lyr_num;
                        busy      <= 1'b1;
                        lyr_idx   <= '0;
                        tile_idx  <= '0;
                    end
                ST_FETCH:
                    if (bus.para_ack) begin
                        tile_num_q <= (bus.para_tile_num == '0) ?
                                      TILE_W'(1) : bus.para_tile_num;
                        tile_idx   <= '0;
                    end
                ST_NEXT: begin
                    if (tile_more)     tile_idx <= tile_idx + TILE_W'(1);
                    else if (lyr_more) lyr_idx  <= lyr_idx + LYR_W'(1);
                end
                ST_FIN:  busy <= 1'b0;
                default: ;
            endcase
        end
    end

    // A new sync event outranks the clear so back-to-back events survive
    always_ff @(posedge clk_trans or negedge rst_n) begin
        if (!rst_n) begin
            cal_done_f <= 1'b0;
            txs_f      <= 1'b0;
        end else if (state == ST_IDLE) begin
            cal_done_f <= 1'b0;
            txs_f      <= 1'b0;
        end else begin
            if (pe_cal_done_sync)
                cal_done_f <= 1'b1;
            else if (trig[P_CAL] || state == ST_WCAL)
                cal_done_f <= 1'b0;
            if (pe_tx_ofm_start_sync)
                txs_f <= 1'b1;
            else if (trig[P_CAL] || state == ST_WTX)
                txs_f <= 1'b0;
        end
    end

    assign bus.para_req        = (state == ST_FETCH);
    assign bus.tx_req          = (state == ST_TX);
    assign pe_ft_lyr_para_done = st_out[P_PARA];
    assign pe_ifm_rst          = st_out[P_IFM];
    assign pe_wt_rst           = st_out[P_WT];
    assign pe_cal_start        = st_out[P_CAL];
    assign pe_tx_ofm_done      = st_out[P_TXD];
    assign pe_first_bn = busy && (lyr_num_q != '0) && (lyr_idx == '0);
    assign pe_last_bn  = busy && (lyr_num_q != '0) &&
                         (lyr_idx == lyr_num_q - LYR_W'(1));
endmodule
